// File: rtl/serial_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the shared serial_tx arbiter.
// slave = arbiter view, master = producers plus transmitter view.
interface serial_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid_in;
  logic [NUM_REQ*WORD_W-1:0] req_data_in;
  logic [NUM_REQ-1:0]        req_ready_out;
  logic [NUM_REQ-1:0]        req_done_out;
  logic                      tx_ready_in;
  logic                      tx_trigger_out;
  logic [WORD_W-1:0]         tx_data_out;
  logic                      busy_out;
  logic                      err_out;

  modport slave (
    input  req_valid_in, req_data_in, tx_ready_in,
    output req_ready_out, req_done_out, tx_trigger_out, tx_data_out, busy_out, err_out
  );

  modport master (
    output req_valid_in, req_data_in, tx_ready_in,
    input  req_ready_out, req_done_out, tx_trigger_out, tx_data_out, busy_out, err_out
  );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Round-robin sharing of one serial_tx among NUM_REQ one-deep holding registers.
// Accept-to-trigger >= 2 cycles; done pulses 1 cycle after tx_ready_in rises; ready = holding register empty.
module serial_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int WORD_W        = 32,
  parameter int START_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n_in,
  serial_tx_arbiter_if.slave   bus
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = $clog2(START_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  pending_q, pending_d;
  logic [WORD_W-1:0]   hold_q [NUM_REQ];
  logic [WORD_W-1:0]   hold_d [NUM_REQ];
  logic [GW-1:0]       last_grant_q, last_grant_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                trigger_q, trigger_d;
  logic [WORD_W-1:0]   tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                err_q, err_d;

  logic [NUM_REQ-1:0]  accept;
  logic [GW-1:0]       winner;
  logic [GW-1:0]       cand;
  logic                found;

  assign accept = bus.req_valid_in & ~pending_q;

  // Search starts one past the last finished or aborted grant and wraps.
  always_comb begin
    winner = last_grant_q;
    cand   = last_grant_q;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant_q) + k) % NUM_REQ);
      if (!found && pending_q[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    hold_d       = hold_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    timer_d      = timer_q;
    trigger_d    = 1'b0;
    tx_data_d    = tx_data_q;
    done_d       = '0;
    err_d        = 1'b0;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        pending_d[i] = 1'b1;
        hold_d[i]    = bus.req_data_in[i*WORD_W +: WORD_W];
      end
    end

    case (state_q)
      IDLE: begin
        if (found && bus.tx_ready_in) begin
          grant_d   = winner;
          tx_data_d = hold_q[winner];
          trigger_d = 1'b1;
          timer_d   = '0;
          state_d   = WAIT_START;
        end
      end
      WAIT_START: begin
        if (!bus.tx_ready_in) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
          // Word stays pending; moving last_grant lets other ports go first.
          err_d        = 1'b1;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (bus.tx_ready_in) begin
          done_d[grant_q]    = 1'b1;
          pending_d[grant_q] = 1'b0;
          last_grant_d       = grant_q;
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      grant_q      <= '0;
      timer_q      <= '0;
      trigger_q    <= 1'b0;
      tx_data_q    <= '0;
      done_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      timer_q      <= timer_d;
      trigger_q    <= trigger_d;
      tx_data_q    <= tx_data_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Payload storage is qualified by pending_q, so it needs no reset.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign bus.req_ready_out  = ~pending_q;
  assign bus.req_done_out   = done_q;
  assign bus.tx_trigger_out = trigger_q;
  assign bus.tx_data_out    = tx_data_q;
  assign bus.busy_out       = (state_q != IDLE);
  assign bus.err_out        = err_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed and random stimulus against a per-edge reference model of the arbiter rules,
// with a simple serial_tx responder driving tx_ready_in.
module tb_serial_tx_arbiter;
  localparam int NR = 4;
  localparam int WW = 32;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_tx_arbiter_if #(.NUM_REQ(NR), .WORD_W(WW)) bus ();

  serial_tx_arbiter #(.NUM_REQ(NR), .WORD_W(WW), .START_TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // reference model state
  logic [NR-1:0] m_pend;
  logic [WW-1:0] m_hold [NR];
  logic [WW-1:0] m_txdata;
  int            m_last, m_g, m_age;
  bit            m_busy, m_dropped;
  logic          exp_trig, exp_err;
  logic [NR-1:0] exp_done;

  // transmitter responder: 0 normal, 1 never leaves ready, 2 held not-ready
  int tx_mode, tx_phase, tx_cnt, d1, d2;
  bit rnd_stuck;

  logic [WW-1:0] vdat [NR];
  logic [WW-1:0] data_log [$];
  int            done_cnt [NR];
  int            err_cnt, last_trig_cyc, last_err_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_pend    = '0;
    m_last    = NR - 1;
    m_g       = 0;
    m_age     = 0;
    m_busy    = 1'b0;
    m_dropped = 1'b0;
    m_txdata  = '0;
    for (int i = 0; i < NR; i++) m_hold[i] = '0;
  endfunction

  task automatic tx_responder();
    case (tx_mode)
      2: begin bus.tx_ready_in = 1'b0; tx_phase = 0; end
      1: begin bus.tx_ready_in = 1'b1; tx_phase = 0; end
      default: begin
        if (tx_phase == 1) begin
          tx_cnt--;
          if (tx_cnt <= 0) begin bus.tx_ready_in = 1'b0; tx_phase = 2; tx_cnt = d2; end
        end else if (tx_phase == 2) begin
          tx_cnt--;
          if (tx_cnt <= 0) begin bus.tx_ready_in = 1'b1; tx_phase = 0; end
        end
        if (exp_trig) begin
          if (!(rnd_stuck && $urandom_range(7) == 0)) begin
            tx_phase = 1;
            tx_cnt   = d1;
          end
        end
      end
    endcase
  endtask

  // One clock: capture the inputs seen at the edge, advance the model, compare all outputs.
  task automatic tick();
    logic [NR-1:0] pv, pend0, exp_rdy;
    logic [WW-1:0] pd [NR];
    logic          pr;
    int            w;
    for (int i = 0; i < NR; i++) bus.req_data_in[i*WW +: WW] = vdat[i];
    pv = bus.req_valid_in;
    pr = bus.tx_ready_in;
    for (int i = 0; i < NR; i++) pd[i] = vdat[i];
    @(posedge clk);
    #1;
    cyc++;
    exp_trig = 1'b0;
    exp_err  = 1'b0;
    exp_done = '0;
    pend0    = m_pend;
    if (m_busy) begin
      m_age++;
      if (!m_dropped) begin
        if (!pr) m_dropped = 1'b1;
        else if (m_age == TO) begin exp_err = 1'b1; m_busy = 1'b0; m_last = m_g; end
      end else if (pr) begin
        exp_done[m_g] = 1'b1;
        m_pend[m_g]   = 1'b0;
        m_busy        = 1'b0;
        m_last        = m_g;
      end
    end else if (pend0 != '0 && pr) begin
      w = -1;
      for (int k = 1; k <= NR; k++)
        if (w < 0 && pend0[(m_last + k) % NR]) w = (m_last + k) % NR;
      m_g       = w;
      m_txdata  = m_hold[w];
      exp_trig  = 1'b1;
      m_busy    = 1'b1;
      m_age     = 0;
      m_dropped = 1'b0;
    end
    for (int i = 0; i < NR; i++)
      if (pv[i] && !pend0[i]) begin m_pend[i] = 1'b1; m_hold[i] = pd[i]; end
    exp_rdy = ~m_pend;
    chk("trigger", bus.tx_trigger_out, exp_trig);
    chk("tx_data", bus.tx_data_out, m_txdata);
    chk("done", bus.req_done_out, exp_done);
    chk("err", bus.err_out, exp_err);
    chk("busy", bus.busy_out, m_busy);
    chk("ready", bus.req_ready_out, exp_rdy);
    if (bus.tx_trigger_out === 1'b1) begin data_log.push_back(bus.tx_data_out); last_trig_cyc = cyc; end
    if (bus.err_out === 1'b1) begin err_cnt++; last_err_cyc = cyc; end
    for (int i = 0; i < NR; i++) if (bus.req_done_out[i] === 1'b1) done_cnt[i]++;
    tx_responder();
  endtask

  // Reset pulse strictly between clock edges; outputs must clear without a clock.
  task automatic async_reset();
    logic [NR-1:0] all_rdy;
    all_rdy = '1;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_trigger", bus.tx_trigger_out, 64'd0);
    chk("rst_tx_data", bus.tx_data_out, 64'd0);
    chk("rst_done", bus.req_done_out, 64'd0);
    chk("rst_err", bus.err_out, 64'd0);
    chk("rst_busy", bus.busy_out, 64'd0);
    chk("rst_ready", bus.req_ready_out, all_rdy);
    #2 rst_n = 1'b1;
    model_reset();
    tx_mode          = 0;
    tx_phase         = 0;
    bus.tx_ready_in  = 1'b1;
    bus.req_valid_in = '0;
  endtask

  task automatic drain(input int budget);
    int n;
    logic [NR:0] obs;
    n = 0;
    while ((bus.busy_out !== 1'b0 || bus.req_ready_out !== {NR{1'b1}}) && n < budget) begin
      tick();
      n++;
    end
    obs = {bus.busy_out, bus.req_ready_out};
    chk("drain_idle", obs, {1'b0, {NR{1'b1}}});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dc;
    logic [WW-1:0] base;
    logic acc;

    bus.req_valid_in = '0;
    bus.req_data_in  = '0;
    bus.tx_ready_in  = 1'b1;
    for (int i = 0; i < NR; i++) begin vdat[i] = '0; done_cnt[i] = 0; end
    tx_mode = 0; tx_phase = 0; tx_cnt = 0; d1 = 2; d2 = 100; rnd_stuck = 1'b0;
    err_cnt = 0; last_trig_cyc = 0; last_err_cyc = 0;
    model_reset();

    // reset state (posedge at t=5 happens with reset asserted)
    #7;
    chk("init_trigger", bus.tx_trigger_out, 64'd0);
    chk("init_busy", bus.busy_out, 64'd0);
    chk("init_ready", bus.req_ready_out, 64'hF);
    chk("init_done", bus.req_done_out, 64'd0);
    #1 rst_n = 1'b1;

    // single request on port 1
    vdat[1] = 32'hDEADBEEF;
    bus.req_valid_in = 4'b0010;
    tick();
    bus.req_valid_in = '0;
    drain(300);
    chk("single_count", data_log.size(), 1);
    chk("single_data", data_log[0], 32'hDEADBEEF);
    chk("single_done", done_cnt[1], 1);
    tick();
    chk("single_ready_after", bus.req_ready_out[1], 1);

    // fairness: all ports always valid
    async_reset();
    data_log.delete();
    d1 = 1; d2 = 3;
    for (int i = 0; i < NR; i++) vdat[i] = 32'h10 + i;
    bus.req_valid_in = '1;
    n = 0;
    while (data_log.size() < 8 && n < 500) begin tick(); n++; end
    bus.req_valid_in = '0;
    drain(500);
    for (int k = 0; k < 8; k++)
      chk($sformatf("fair_%0d", k), data_log[k], 32'h10 + (k % NR));

    // start timeout with ports 0 and 2 pending
    async_reset();
    data_log.delete();
    err_cnt = 0;
    tx_mode = 1;
    vdat[0] = 32'hA0; vdat[2] = 32'hA2;
    bus.req_valid_in = 4'b0101;
    tick();
    bus.req_valid_in = '0;
    n = 0;
    while (err_cnt == 0 && n < 100) begin tick(); n++; end
    chk("to_err_delay", last_err_cyc - last_trig_cyc, 16);
    chk("to_still_pending", bus.req_ready_out[0], 0);
    tx_mode = 0; d1 = 2; d2 = 5;
    drain(300);
    chk("to_order0", data_log[0], 32'hA0);
    chk("to_order1", data_log[1], 32'hA2);
    chk("to_order2", data_log[2], 32'hA0);
    chk("to_err_count", err_cnt, 1);

    // back-pressure: transmitter not ready
    async_reset();
    data_log.delete();
    tx_mode = 2;
    bus.tx_ready_in = 1'b0;
    vdat[0] = 32'hB0; vdat[3] = 32'hB3;
    bus.req_valid_in = 4'b1001;
    tick();
    bus.req_valid_in = '0;
    repeat (20) tick();
    chk("bp_no_trigger", data_log.size(), 0);
    chk("bp_busy", bus.busy_out, 0);
    tx_mode = 0; bus.tx_ready_in = 1'b1; d1 = 2; d2 = 4;
    drain(300);
    chk("bp_first", data_log[0], 32'hB0);
    chk("bp_second", data_log[1], 32'hB3);

    // same port re-requesting with incrementing data
    async_reset();
    data_log.delete();
    base = 32'h0000_2000;
    vdat[2] = base;
    bus.req_valid_in = 4'b0100;
    n = 0;
    while (data_log.size() < 6 && n < 2000) begin
      d1  = int'($urandom_range(1, 4));
      d2  = int'($urandom_range(1, 12));
      acc = bus.req_ready_out[2];
      tick();
      n++;
      if (acc) vdat[2] = vdat[2] + 32'd1;
    end
    bus.req_valid_in = '0;
    drain(300);
    for (int k = 0; k < 6; k++)
      chk($sformatf("same_port_%0d", k), data_log[k], base + k);

    // random traffic with occasional stuck transmitter
    async_reset();
    data_log.delete();
    rnd_stuck = 1'b1;
    repeat (1500) begin
      bus.req_valid_in = NR'($urandom);
      for (int i = 0; i < NR; i++) vdat[i] = $urandom;
      d1 = int'($urandom_range(1, 5));
      d2 = int'($urandom_range(1, 15));
      tick();
    end
    bus.req_valid_in = '0;
    rnd_stuck = 1'b0;
    drain(800);

    // asynchronous reset while waiting for completion
    async_reset();
    data_log.delete();
    d1 = 2; d2 = 60;
    vdat[1] = 32'hC1;
    bus.req_valid_in = 4'b0010;
    tick();
    bus.req_valid_in = '0;
    n = 0;
    while (bus.tx_ready_in && n < 50) begin tick(); n++; end
    repeat (5) tick();
    chk("pre_rst_busy", bus.busy_out, 1);
    dc = done_cnt[1];
    async_reset();
    data_log.delete();
    vdat[0] = 32'hD0; vdat[2] = 32'hD2;
    bus.req_valid_in = 4'b0101;
    tick();
    bus.req_valid_in = '0;
    d1 = 2; d2 = 4;
    drain(300);
    chk("post_rst_no_done", done_cnt[1], dc);
    chk("post_rst_first", data_log[0], 32'hD0);
    chk("post_rst_second", data_log[1], 32'hD2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
